// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler that lets two requesters share one external 16-bit ALU.
// Latency: a grant in cycle T gives rsp_valid in cycle T+2; one op in flight, so ops issue every 3 cycles.
// Backpressure: while rsp_ready is low the result is held in RESP and no new grant is issued.
// Optional feature macro: ALU_SCHED_STICKY_OFL_EN adds ofl_clr/ofl_sticky, a per-requester sticky overflow.

module alu_sched #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         r0_req,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    input  logic [6:0]   r0_ctl,
    output logic         r0_gnt,

    input  logic         r1_req,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    input  logic [6:0]   r1_ctl,
    output logic         r1_gnt,

    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_cin,
    output logic [2:0]   alu_op,
    output logic         alu_inva,
    output logic         alu_invb,
    output logic         alu_sign,
    input  logic [W-1:0] alu_out,
    input  logic         alu_ofl,
    input  logic         alu_z,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_out,
    output logic         rsp_ofl,
    output logic         rsp_z
`ifdef ALU_SCHED_STICKY_OFL_EN
    ,
    input  logic [1:0]   ofl_clr,
    output logic [1:0]   ofl_sticky
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state;
    logic           last;      // id of the most recent grant
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [6:0]     op_ctl;    // {sign, invB, invA, Cin, Op[2:0]}
    logic           op_id;

    logic           grant;
    logic           win_id;

    // Round-robin pick in IDLE: a tie goes to the requester that did not win last time.
    always_comb begin
        grant  = 1'b0;
        win_id = 1'b0;
        if (rst_n && (state == ST_IDLE)) begin
            if (r0_req && r1_req) begin
                grant  = 1'b1;
                win_id = ~last;
            end else if (r0_req) begin
                grant  = 1'b1;
                win_id = 1'b0;
            end else if (r1_req) begin
                grant  = 1'b1;
                win_id = 1'b1;
            end
        end
        r0_gnt = grant & ~win_id;
        r1_gnt = grant &  win_id;
    end

    // The ALU pins always mirror the operand registers; they only matter during EXEC.
    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_op   = op_ctl[2:0];
    assign alu_cin  = op_ctl[3];
    assign alu_inva = op_ctl[4];
    assign alu_invb = op_ctl[5];
    assign alu_sign = op_ctl[6];

    // Sequencer: capture the winner, spend one cycle on the ALU, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            op_a      <= '0;
            op_b      <= '0;
            op_ctl    <= '0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= '0;
            rsp_ofl   <= 1'b0;
            rsp_z     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        op_a   <= win_id ? r1_a   : r0_a;
                        op_b   <= win_id ? r1_b   : r0_b;
                        op_ctl <= win_id ? r1_ctl : r0_ctl;
                        op_id  <= win_id;
                        last   <= win_id;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Shifts (Op[2]=0) have no meaningful overflow, so it is masked off.
                    rsp_out   <= alu_out;
                    rsp_z     <= alu_z;
                    rsp_ofl   <= alu_ofl & op_ctl[2];
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SCHED_STICKY_OFL_EN
    logic [1:0] sticky_set;

    // One-hot set for the requester whose overflowing result is being handed over.
    assign sticky_set = (rsp_valid && rsp_ready && rsp_ofl) ? {rsp_id, ~rsp_id} : 2'b00;

    // Sticky overflow per requester; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ofl_sticky <= 2'b00;
        end else begin
            ofl_sticky <= (ofl_sticky & ~ofl_clr) | sticky_set;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scenario tasks plus randomized traffic against a queue-based reference model.
// Latency: checks grant-to-response distance of 2 cycles and a 3-cycle issue interval.
// Backpressure: holds rsp_ready low to confirm the result and arbitration freeze.

module tb_alu_sched;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         r0_req, r1_req;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [6:0]   r0_ctl, r1_ctl;
    logic         r0_gnt, r1_gnt;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_cin, alu_inva, alu_invb, alu_sign, alu_ofl, alu_z;
    logic [2:0]   alu_op;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_ofl, rsp_z;
    logic [W-1:0] rsp_out;
`ifdef ALU_SCHED_STICKY_OFL_EN
    logic [1:0]   ofl_clr;
    logic [1:0]   ofl_sticky;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] out;
        logic         ofl;
        logic         z;
        int           gcyc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    alu_sched #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_a(r0_a), .r0_b(r0_b), .r0_ctl(r0_ctl), .r0_gnt(r0_gnt),
        .r1_req(r1_req), .r1_a(r1_a), .r1_b(r1_b), .r1_ctl(r1_ctl), .r1_gnt(r1_gnt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_inva(alu_inva), .alu_invb(alu_invb), .alu_sign(alu_sign),
        .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_ofl(rsp_ofl), .rsp_z(rsp_z)
`ifdef ALU_SCHED_STICKY_OFL_EN
        , .ofl_clr(ofl_clr), .ofl_sticky(ofl_sticky)
`endif
    );

    // Behavioural ALU: returns {ofl, out}. Ops other than add report ofl=1 as garbage.
    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [6:0] ctl);
        logic [W-1:0] aa, bb, o;
        logic [W:0]   s;
        logic         ofl;
        int           sh;
        aa  = ctl[4] ? ~a : a;
        bb  = ctl[5] ? ~b : b;
        sh  = int'(bb[3:0]);
        ofl = 1'b1;
        case (ctl[2:0])
            3'b000: o = (aa << sh) | (aa >> (W - sh));
            3'b001: o = aa << sh;
            3'b010: o = (aa >> sh) | (aa << (W - sh));
            3'b011: o = aa >> sh;
            3'b100: begin
                s   = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ctl[3]};
                o   = s[W-1:0];
                ofl = ctl[6] ? ((aa[W-1] == bb[W-1]) && (o[W-1] != aa[W-1])) : s[W];
            end
            3'b101: o = aa | bb;
            3'b110: o = aa ^ bb;
            default: o = aa & bb;
        endcase
        return {ofl, o};
    endfunction

    // External ALU driven from the scheduler's pins.
    always_comb {alu_ofl, alu_out} = alu_ref(alu_a, alu_b, {alu_sign, alu_invb, alu_inva, alu_cin, alu_op});
    assign alu_z = (alu_out == '0);

    function automatic exp_t make_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [6:0] ctl, input int gc);
        exp_t       e;
        logic [W:0] r;
        r      = alu_ref(a, b, ctl);
        e.id   = id;
        e.out  = r[W-1:0];
        e.ofl  = r[W] & ctl[2];
        e.z    = (r[W-1:0] == '0);
        e.gcyc = gc;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b1;
        r0_req = 1'b1; r0_a = 16'h1111; r0_b = 16'h2222; r0_ctl = 7'h44;
        r1_req = 1'b1; r1_a = 16'h3333; r1_b = 16'h4444; r1_ctl = 7'h45;
`ifdef ALU_SCHED_STICKY_OFL_EN
        ofl_clr = 2'b00;
`endif
        step(); step();
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {r0_gnt, r1_gnt}); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        checks++; if ({rsp_id, rsp_out, rsp_ofl, rsp_z} !== '0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {rsp_id, rsp_out, rsp_ofl, rsp_z}); end
        checks++; if ({alu_a, alu_b} !== '0) begin errors++; $display("FAIL reset_alu_ab got %h exp 0", {alu_a, alu_b}); end
        checks++; if ({alu_sign, alu_invb, alu_inva, alu_cin, alu_op} !== 7'h00) begin errors++; $display("FAIL reset_alu_ctl got %h exp 00", {alu_sign, alu_invb, alu_inva, alu_cin, alu_op}); end
`ifdef ALU_SCHED_STICKY_OFL_EN
        checks++; if (ofl_sticky !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", ofl_sticky); end
`endif
        step();
        r0_req = 1'b0; r1_req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt, rsp_valid} !== 3'b000) begin errors++; $display("FAIL reset_idle got %b exp 000", {r0_gnt, r1_gnt, rsp_valid}); end
    endtask

    task automatic test_single_op();
        step();
        r0_req = 1'b1; r0_a = 16'h7FFF; r0_b = 16'h0001; r0_ctl = 7'b1000100;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL single_gnt got %b exp 10", {r0_gnt, r1_gnt}); end
        step();
        r0_req = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec_valid got %b exp 0", rsp_valid); end
        checks++; if ({alu_a, alu_b} !== {16'h7FFF, 16'h0001}) begin errors++; $display("FAIL single_exec_ab got %h exp 7fff0001", {alu_a, alu_b}); end
        checks++; if ({alu_sign, alu_invb, alu_inva, alu_cin, alu_op} !== 7'b1000100) begin errors++; $display("FAIL single_exec_ctl got %b exp 1000100", {alu_sign, alu_invb, alu_inva, alu_cin, alu_op}); end
        step();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
        checks++; if ({rsp_id, rsp_out, rsp_ofl, rsp_z} !== {1'b0, 16'h8000, 1'b1, 1'b0}) begin errors++; $display("FAIL single_rsp got id=%b out=%h ofl=%b z=%b exp id=0 out=8000 ofl=1 z=0", rsp_id, rsp_out, rsp_ofl, rsp_z); end
        step();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done got %b exp 0", rsp_valid); end
`ifdef ALU_SCHED_STICKY_OFL_EN
        checks++; if (ofl_sticky !== 2'b01) begin errors++; $display("FAIL sticky_set got %b exp 01", ofl_sticky); end
        step();
        ofl_clr = 2'b01;
        step();
        ofl_clr = 2'b00;
        @(negedge clk);
        checks++; if (ofl_sticky !== 2'b00) begin errors++; $display("FAIL sticky_clr got %b exp 00", ofl_sticky); end
`endif
    endtask

    task automatic test_shift_mask();
        step();
        r1_req = 1'b1; r1_a = 16'h0003; r1_b = 16'h0004; r1_ctl = 7'b0000001;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL shift_gnt got %b exp 01", {r0_gnt, r1_gnt}); end
        step();
        r1_req = 1'b0;
        step();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_ofl} !== {1'b1, 1'b1, 16'h0030, 1'b0}) begin errors++; $display("FAIL shift_rsp got v=%b id=%b out=%h ofl=%b exp v=1 id=1 out=0030 ofl=0", rsp_valid, rsp_id, rsp_out, rsp_ofl); end
        step();
`ifdef ALU_SCHED_STICKY_OFL_EN
        @(negedge clk);
        checks++; if (ofl_sticky !== 2'b00) begin errors++; $display("FAIL shift_sticky got %b exp 00", ofl_sticky); end
`endif
    endtask

    task automatic test_zero_flag();
        step();
        r0_req = 1'b1; r0_a = 16'h1234; r0_b = 16'h1234; r0_ctl = 7'b0101100;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL zero_gnt got %b exp 1", r0_gnt); end
        step();
        r0_req = 1'b0;
        step();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_out, rsp_z, rsp_ofl} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin errors++; $display("FAIL zero_rsp got v=%b out=%h z=%b ofl=%b exp v=1 out=0000 z=1 ofl=1", rsp_valid, rsp_out, rsp_z, rsp_ofl); end
        step();
    endtask

    task automatic test_backpressure();
        exp_t e0, e1;
        rsp_ready = 1'b0;
        step();
        r0_req = 1'b1; r0_a = 16'($urandom); r0_b = 16'($urandom); r0_ctl = 7'($urandom);
        e0 = make_exp(1'b0, r0_a, r0_b, r0_ctl, 0);
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt0 got %b exp 1", r0_gnt); end
        step();
        r0_req = 1'b0;
        r1_req = 1'b1; r1_a = 16'($urandom); r1_b = 16'($urandom); r1_ctl = 7'($urandom);
        e1 = make_exp(1'b1, r1_a, r1_b, r1_ctl, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_ofl, rsp_z} !== {1'b1, e0.id, e0.out, e0.ofl, e0.z}) begin errors++; $display("FAIL bp_hold[%0d] got v=%b id=%b out=%h ofl=%b z=%b exp v=1 id=%b out=%h ofl=%b z=%b", i, rsp_valid, rsp_id, rsp_out, rsp_ofl, rsp_z, e0.id, e0.out, e0.ofl, e0.z); end
            checks++; if ({r0_gnt, r1_gnt} !== 2'b00) begin errors++; $display("FAIL bp_nognt[%0d] got %b exp 00", i, {r0_gnt, r1_gnt}); end
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid got %b exp 1", rsp_valid); end
        step();
        @(negedge clk);
        checks++; if ({rsp_valid, r1_gnt} !== 2'b01) begin errors++; $display("FAIL bp_after got valid=%b gnt1=%b exp valid=0 gnt1=1", rsp_valid, r1_gnt); end
        step();
        r1_req = 1'b0;
        step();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_ofl, rsp_z} !== {1'b1, e1.id, e1.out, e1.ofl, e1.z}) begin errors++; $display("FAIL bp_second got id=%b out=%h ofl=%b z=%b exp id=%b out=%h ofl=%b z=%b", rsp_id, rsp_out, rsp_ofl, rsp_z, e1.id, e1.out, e1.ofl, e1.z); end
        step();
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        step();
        r1_req = 1'b1; r1_a = 16'h00F0; r1_b = 16'h000F; r1_ctl = 7'b0000101;
        @(negedge clk);
        checks++; if (r1_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", r1_gnt); end
        step();
        rst_n = 1'b0;
        r0_req = 1'b1; r0_a = 16'($urandom); r0_b = 16'($urandom); r0_ctl = 7'($urandom);
        r1_a = 16'($urandom); r1_b = 16'($urandom); r1_ctl = 7'($urandom);
        e = make_exp(1'b0, r0_a, r0_b, r0_ctl, 0);
        step();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_ofl, rsp_z} !== '0) begin errors++; $display("FAIL rmid_rsp got %h exp 0", {rsp_valid, rsp_id, rsp_out, rsp_ofl, rsp_z}); end
        checks++; if ({alu_a, alu_b} !== '0) begin errors++; $display("FAIL rmid_alu got %h exp 0", {alu_a, alu_b}); end
        checks++; if ({r0_gnt, r1_gnt} !== 2'b00) begin errors++; $display("FAIL rmid_gnt_in_reset got %b exp 00", {r0_gnt, r1_gnt}); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL rmid_first got %b exp 10", {r0_gnt, r1_gnt}); end
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        step();
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_ofl, rsp_z} !== {1'b1, e.id, e.out, e.ofl, e.z}) begin errors++; $display("FAIL rmid_rsp_after got v=%b id=%b out=%h exp v=1 id=%b out=%h", rsp_valid, rsp_id, rsp_out, e.id, e.out); end
        step();
    endtask

    task automatic test_contention();
        int   gid[4];
        int   gcy[4];
        int   ng, nr, g;
        exp_t e;
        for (int i = 0; i < 4; i++) begin gid[i] = -1; gcy[i] = -100; end
        ng = 0; nr = 0;
        q.delete();
        step();
        rst_n = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
        step();
        rst_n = 1'b1; rsp_ready = 1'b1;
        r0_req = 1'b1; r0_a = 16'($urandom); r0_b = 16'($urandom); r0_ctl = 7'($urandom);
        r1_req = 1'b1; r1_a = 16'($urandom); r1_b = 16'($urandom); r1_ctl = 7'($urandom);
        for (int c = 0; c < 40 && (ng < 4 || nr < 4); c++) begin
            g = -1;
            @(negedge clk);
            checks++; if ((r0_gnt & r1_gnt) !== 1'b0) begin errors++; $display("FAIL cont_double_gnt cycle %0d got 1 exp 0", c); end
            if (rsp_valid) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL cont_spurious_rsp cycle %0d got valid exp none", c); end
                else begin
                    e = q.pop_front(); nr++;
                    if ({rsp_id, rsp_out, rsp_ofl, rsp_z} !== {e.id, e.out, e.ofl, e.z}) begin errors++; $display("FAIL cont_rsp got id=%b out=%h ofl=%b z=%b exp id=%b out=%h ofl=%b z=%b", rsp_id, rsp_out, rsp_ofl, rsp_z, e.id, e.out, e.ofl, e.z); end
                end
            end
            if (r0_gnt || r1_gnt) begin
                g = r1_gnt ? 1 : 0;
                if (ng < 4) begin gid[ng] = g; gcy[ng] = c; end
                ng++;
                if (g == 1) q.push_back(make_exp(1'b1, r1_a, r1_b, r1_ctl, c));
                else        q.push_back(make_exp(1'b0, r0_a, r0_b, r0_ctl, c));
            end
            step();
            if (g == 0) begin r0_a = 16'($urandom); r0_b = 16'($urandom); r0_ctl = 7'($urandom); end
            if (g == 1) begin r1_a = 16'($urandom); r1_b = 16'($urandom); r1_ctl = 7'($urandom); end
            if (ng >= 4) begin r0_req = 1'b0; r1_req = 1'b0; end
        end
        checks++; if (ng !== 4) begin errors++; $display("FAIL cont_grant_count got %0d exp 4", ng); end
        checks++; if (nr !== 4) begin errors++; $display("FAIL cont_rsp_count got %0d exp 4", nr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (gid[i] !== (i % 2)) begin errors++; $display("FAIL cont_order[%0d] got %0d exp %0d", i, gid[i], i % 2); end
        end
        for (int i = 1; i < 4; i++) begin
            checks++; if ((gcy[i] - gcy[i-1]) !== 3) begin errors++; $display("FAIL cont_gap[%0d] got %0d exp 3", i, gcy[i] - gcy[i-1]); end
        end
    endtask

    task automatic test_random();
        logic       pend0, pend1, last_m, idle, g0, g1, v_exp;
        logic [1:0] sticky_m, clr;
        exp_t       e;
        q.delete();
        pend0 = 1'b0; pend1 = 1'b0; last_m = 1'b1; sticky_m = 2'b00; clr = 2'b00;
        step();
        rst_n = 1'b0; r0_req = 1'b0; r1_req = 1'b0; rsp_ready = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (!pend0) begin
                r0_req = ($urandom_range(0, 1) == 1);
                if (r0_req) begin pend0 = 1'b1; r0_a = 16'($urandom); r0_b = 16'($urandom); r0_ctl = 7'($urandom); end
            end else if ($urandom_range(0, 9) == 0) begin
                r0_req = 1'b0; pend0 = 1'b0;
            end
            if (!pend1) begin
                r1_req = ($urandom_range(0, 1) == 1);
                if (r1_req) begin pend1 = 1'b1; r1_a = 16'($urandom); r1_b = 16'($urandom); r1_ctl = 7'($urandom); end
            end else if ($urandom_range(0, 9) == 0) begin
                r1_req = 1'b0; pend1 = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
`ifdef ALU_SCHED_STICKY_OFL_EN
            ofl_clr = clr;
`endif
            idle  = (q.size() == 0);
            g0    = idle && r0_req && (!r1_req || last_m);
            g1    = idle && r1_req && (!r0_req || !last_m);
            v_exp = (q.size() > 0) && (c >= q[0].gcyc + 2);
            @(negedge clk);
            checks++; if ({r0_gnt, r1_gnt} !== {g0, g1}) begin errors++; $display("FAIL rand_gnt cycle %0d got %b exp %b", c, {r0_gnt, r1_gnt}, {g0, g1}); end
            checks++; if (rsp_valid !== v_exp) begin errors++; $display("FAIL rand_valid cycle %0d got %b exp %b", c, rsp_valid, v_exp); end
`ifdef ALU_SCHED_STICKY_OFL_EN
            checks++; if (ofl_sticky !== sticky_m) begin errors++; $display("FAIL rand_sticky cycle %0d got %b exp %b", c, ofl_sticky, sticky_m); end
`endif
            if (v_exp) begin
                e = q[0];
                checks++; if ({rsp_id, rsp_out, rsp_ofl, rsp_z} !== {e.id, e.out, e.ofl, e.z}) begin errors++; $display("FAIL rand_rsp cycle %0d got id=%b out=%h ofl=%b z=%b exp id=%b out=%h ofl=%b z=%b", c, rsp_id, rsp_out, rsp_ofl, rsp_z, e.id, e.out, e.ofl, e.z); end
                sticky_m = sticky_m & ~clr;
                if (rsp_ready) begin
                    if (e.ofl) sticky_m[e.id] = 1'b1;
                    void'(q.pop_front());
                end
            end else begin
                sticky_m = sticky_m & ~clr;
            end
            if (g0) begin q.push_back(make_exp(1'b0, r0_a, r0_b, r0_ctl, c)); last_m = 1'b0; pend0 = 1'b0; end
            if (g1) begin q.push_back(make_exp(1'b1, r1_a, r1_b, r1_ctl, c)); last_m = 1'b1; pend1 = 1'b0; end
            step();
        end
        r0_req = 1'b0; r1_req = 1'b0; rsp_ready = 1'b1;
`ifdef ALU_SCHED_STICKY_OFL_EN
        ofl_clr = 2'b00;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_shift_mask();
        test_zero_flag();
        test_backpressure();
        test_reset_mid_op();
        test_contention();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
